// File: rtl/aq_hpcp_pkg.sv
// Shared encodings for the HPCP controller: CSR FSM states, register selects
// and control-register field offsets.
package aq_hpcp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_RESP  = 2'd3
  } hpcp_state_e;

  typedef enum logic [1:0] {
    SEL_CNT  = 2'd0,
    SEL_EVT  = 2'd1,
    SEL_CTRL = 2'd2,
    SEL_OFST = 2'd3
  } hpcp_sel_e;

  // Control register layout: inhibit bits from bit 0, irq enables from bit 32
  localparam int CTRL_INH_OFS = 0;
  localparam int CTRL_IRQ_OFS = 32;

endpackage

// File: rtl/aq_hpcp_ctrl_if.sv
// CSR request/acknowledge bundle between CP0 (master) and the HPCP controller (slave).
// Request is held until a one-cycle ack; read data is valid only with ack.
// Master drops req in the cycle after ack.
interface aq_hpcp_ctrl_if;
  logic        hpcp_csr_req;
  logic        hpcp_csr_wr;
  logic [1:0]  hpcp_csr_sel;
  logic [4:0]  hpcp_csr_idx;
  logic [63:0] hpcp_csr_wdata;
  logic        hpcp_csr_ack;
  logic [63:0] hpcp_csr_rdata;

  modport master (
    output hpcp_csr_req, hpcp_csr_wr, hpcp_csr_sel, hpcp_csr_idx, hpcp_csr_wdata,
    input  hpcp_csr_ack, hpcp_csr_rdata
  );

  modport slave (
    input  hpcp_csr_req, hpcp_csr_wr, hpcp_csr_sel, hpcp_csr_idx, hpcp_csr_wdata,
    output hpcp_csr_ack, hpcp_csr_rdata
  );
endinterface

// File: rtl/aq_hpcp_evt_sel.sv
// Per-counter event select register, event mux, enable and clock-enable generation.
// Latency: event select write visible the cycle after its edge; adder is combinational from evt_ff.
// No backpressure: driven directly by the controller's decoded write strobe.
module aq_hpcp_evt_sel #(
  parameter int EVT_NUM = 32,
  parameter int EVT_W   = 5
) (
  input  logic               forever_cpuclk,
  input  logic               cpurst_b,
  input  logic               i_sel_wen,
  input  logic [EVT_W-1:0]   i_sel_wdata,
  input  logic               i_inhibit,
  input  logic               i_freeze,
  input  logic [EVT_NUM-1:0] i_evt_ff,
  input  logic               i_cnt_wen,
  input  logic               i_cnt_of,
  output logic [EVT_W-1:0]   o_evt_sel,
  output logic               o_cnt_en,
  output logic               o_cnt_adder,
  output logic               o_cnt_clk_en
);

  logic [EVT_W-1:0]         r_evt_sel;
  logic                     r_en_d;
  logic [(1<<EVT_W)-1:0]    w_evt_pad;

  // Event select register and one-cycle-delayed enable
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_evt_sel <= '0;
      r_en_d    <= 1'b0;
    end else begin
      if (i_sel_wen) r_evt_sel <= i_sel_wdata;
      r_en_d <= o_cnt_en;
    end
  end

  // Zero-pad the event vector so codes at or above EVT_NUM select a constant 0
  always_comb begin
    w_evt_pad = '0;
    w_evt_pad[EVT_NUM-1:0] = i_evt_ff;
  end

  assign o_evt_sel    = r_evt_sel;
  assign o_cnt_en     = (r_evt_sel != '0) & ~i_inhibit & ~i_freeze;
  assign o_cnt_adder  = w_evt_pad[r_evt_sel];
  // en_d lets the counter clock its enable flop low; cnt_of lets its overflow flop self-clear
  assign o_cnt_clk_en = o_cnt_en | r_en_d | i_cnt_wen | i_cnt_of;

endmodule

// File: rtl/aq_hpcp_ctrl.sv
// HPCP controller: CSR FSM, control/overflow registers and per-counter drive. Optional
// freeze-on-overflow build macro: AQ_HPCP_OF_FREEZE_EN.
// Latency: write strobe one cycle after req is sampled, ack two cycles after; req held until ack.
module aq_hpcp_ctrl
  import aq_hpcp_pkg::*;
#(
  parameter int CNT_NUM = 8,
  parameter int EVT_NUM = 32,
  parameter int EVT_W   = 5
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  aq_hpcp_ctrl_if.slave          csr,
  input  logic [EVT_NUM-1:0]     evt_vld,
  input  logic [64*CNT_NUM-1:0]  cnt_value,
  input  logic [CNT_NUM-1:0]     cnt_of,
  output logic [CNT_NUM-1:0]     ctrl_cnt_en,
  output logic [CNT_NUM-1:0]     ctrl_cnt_adder,
  output logic [CNT_NUM-1:0]     ctrl_cnt_wen,
  output logic [CNT_NUM-1:0]     ctrl_cnt_clk_en,
  output logic [63:0]            ctrl_hpcp_wdata,
  output logic                   hpcp_of_irq
);

  hpcp_state_e          r_state;
  logic                 r_wr;
  hpcp_sel_e            r_sel;
  logic [4:0]           r_idx;
  logic [63:0]          r_wdata;
  logic [63:0]          r_rdata_q;
  logic                 r_ack;
  logic [CNT_NUM-1:0]   r_inhibit;
  logic [CNT_NUM-1:0]   r_irq_en;
  logic [CNT_NUM-1:0]   r_of_pend;
  logic [EVT_NUM-1:0]   r_evt_ff;

  logic [CNT_NUM-1:0]   w_sel_wen;
  logic [CNT_NUM-1:0]   w_of_clr;
  logic [63:0]          w_rd_mux;
  logic                 w_freeze;
  logic [EVT_W-1:0]     w_evt_sel [CNT_NUM];

`ifdef AQ_HPCP_OF_FREEZE_EN
  assign w_freeze = |r_of_pend;
`else
  assign w_freeze = 1'b0;
`endif

  // Decode the one-hot per-counter write strobes; out-of-range indices match nothing
  always_comb begin
    ctrl_cnt_wen = '0;
    w_sel_wen    = '0;
    for (int i = 0; i < CNT_NUM; i++) begin
      if (r_state == ST_WRITE && r_idx == 5'(i)) begin
        ctrl_cnt_wen[i] = (r_sel == SEL_CNT);
        w_sel_wen[i]    = (r_sel == SEL_EVT);
      end
    end
  end

  // Read mux; out-of-range indices leave the result at 0
  always_comb begin
    w_rd_mux = '0;
    case (r_sel)
      SEL_CNT: begin
        for (int i = 0; i < CNT_NUM; i++)
          if (r_idx == 5'(i)) w_rd_mux = cnt_value[64*i +: 64];
      end
      SEL_EVT: begin
        for (int i = 0; i < CNT_NUM; i++)
          if (r_idx == 5'(i)) w_rd_mux[EVT_W-1:0] = w_evt_sel[i];
      end
      SEL_CTRL: begin
        w_rd_mux[CTRL_INH_OFS +: CNT_NUM] = r_inhibit;
        w_rd_mux[CTRL_IRQ_OFS +: CNT_NUM] = r_irq_en;
      end
      SEL_OFST: w_rd_mux[CNT_NUM-1:0] = r_of_pend;
      default:  w_rd_mux = '0;
    endcase
  end

  assign w_of_clr = (r_state == ST_WRITE && r_sel == SEL_OFST) ? r_wdata[CNT_NUM-1:0] : '0;

  // CSR FSM: latch request, perform one write or read cycle, then a registered ack cycle
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_state   <= ST_IDLE;
      r_wr      <= 1'b0;
      r_sel     <= SEL_CNT;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_rdata_q <= '0;
      r_ack     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          if (csr.hpcp_csr_req) begin
            r_wr    <= csr.hpcp_csr_wr;
            r_sel   <= hpcp_sel_e'(csr.hpcp_csr_sel);
            r_idx   <= csr.hpcp_csr_idx;
            r_wdata <= csr.hpcp_csr_wdata;
            r_state <= csr.hpcp_csr_wr ? ST_WRITE : ST_READ;
          end
        end
        ST_WRITE: begin
          r_ack   <= 1'b1;
          r_state <= ST_RESP;
        end
        ST_READ: begin
          r_rdata_q <= w_rd_mux;
          r_ack     <= 1'b1;
          r_state   <= ST_RESP;
        end
        default: begin
          r_ack     <= 1'b0;
          r_rdata_q <= '0;
          r_state   <= ST_IDLE;
        end
      endcase
    end
  end

  // Control, overflow-pending (set beats clear) and registered event hits
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_inhibit <= '0;
      r_irq_en  <= '0;
      r_of_pend <= '0;
      r_evt_ff  <= '0;
    end else begin
      if (r_state == ST_WRITE && r_sel == SEL_CTRL) begin
        r_inhibit <= r_wdata[CTRL_INH_OFS +: CNT_NUM];
        r_irq_en  <= r_wdata[CTRL_IRQ_OFS +: CNT_NUM];
      end
      r_of_pend <= (r_of_pend & ~w_of_clr) | cnt_of;
      r_evt_ff  <= evt_vld;
    end
  end

  assign csr.hpcp_csr_ack   = r_ack;
  assign csr.hpcp_csr_rdata = r_rdata_q;
  assign ctrl_hpcp_wdata    = (r_state == ST_WRITE) ? r_wdata : '0;
  assign hpcp_of_irq        = |(r_of_pend & r_irq_en);

  for (genvar g = 0; g < CNT_NUM; g++) begin : g_cnt
    aq_hpcp_evt_sel #(.EVT_NUM(EVT_NUM), .EVT_W(EVT_W)) u_evt_sel (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .i_sel_wen      (w_sel_wen[g]),
      .i_sel_wdata    (r_wdata[EVT_W-1:0]),
      .i_inhibit      (r_inhibit[g]),
      .i_freeze       (w_freeze),
      .i_evt_ff       (r_evt_ff),
      .i_cnt_wen      (ctrl_cnt_wen[g]),
      .i_cnt_of       (cnt_of[g]),
      .o_evt_sel      (w_evt_sel[g]),
      .o_cnt_en       (ctrl_cnt_en[g]),
      .o_cnt_adder    (ctrl_cnt_adder[g]),
      .o_cnt_clk_en   (ctrl_cnt_clk_en[g])
    );
  end

endmodule

// File: doc/aq_hpcp_ctrl.md
# aq_hpcp_ctrl

Controller for a bank of `CNT_NUM` hardware performance counters of the `aq_hpcp_cnt` type. It owns the per-counter event-select, inhibit and overflow-interrupt state. It serialises CSR reads and writes from the CP0 side into single-cycle counter write strobes, and drives each counter's enable, event-hit and clock-enable inputs. It sits between CP0 and the counter instances inside the PMU.

## Interface
Parameters:
- `CNT_NUM`, 8: number of counters; 1..32.
- `EVT_NUM`, 32: number of event inputs; event code 0 means "no event".
- `EVT_W`, 5: event-select width; `2**EVT_W >= EVT_NUM`.

Ports:
- `forever_cpuclk`  in  1  clock; single clock domain.
- `cpurst_b`  in  1  asynchronous active-low reset.
- `hpcp_csr_req`  in  1  access request; held high until `hpcp_csr_ack`.
- `hpcp_csr_wr`  in  1  1 = write, 0 = read; stable while req is high.
- `hpcp_csr_sel`  in  2  register select: 0 = counter value, 1 = event select, 2 = control, 3 = overflow status.
- `hpcp_csr_idx`  in  5  counter index; used for sel 0 and sel 1.
- `hpcp_csr_wdata`  in  64  write data.
- `hpcp_csr_ack`  out  1  one-cycle completion pulse.
- `hpcp_csr_rdata`  out  64  read data; valid only while ack is high, 0 otherwise.
- `evt_vld`  in  EVT_NUM  per-cycle event hits.
- `cnt_value`  in  64*CNT_NUM  counter values; counter i occupies bits [64i+63:64i].
- `cnt_of`  in  CNT_NUM  counter overflow pulses.
- `ctrl_cnt_en`  out  CNT_NUM  counting enable.
- `ctrl_cnt_adder`  out  CNT_NUM  selected event hit.
- `ctrl_cnt_wen`  out  CNT_NUM  counter write strobe.
- `ctrl_cnt_clk_en`  out  CNT_NUM  local clock enable for the counter's gated clock.
- `ctrl_hpcp_wdata`  out  64  counter write data.
- `hpcp_of_irq`  out  1  overflow interrupt, level.

## Operation
Registers. All reset to 0.
- `evt_sel[i]`: EVT_W bits per counter.
- `ctrl`: bits [CNT_NUM-1:0] are inhibit; bits [32+CNT_NUM-1:32] are irq_en.
- `of_pend`: CNT_NUM bits.
- `evt_ff`: `evt_vld` registered one cycle.

Counting controls, all combinational:
- `ctrl_cnt_en[i] = (evt_sel[i] != 0) & ~inhibit[i] & ~freeze`.
- `ctrl_cnt_adder[i] = evt_ff[evt_sel[i]]`. Codes `>= EVT_NUM` select 0.
- `ctrl_cnt_clk_en[i] = ctrl_cnt_en[i] | en_d[i] | ctrl_cnt_wen[i] | cnt_of[i]`.
  - `en_d` is `ctrl_cnt_en` delayed one cycle. It clocks the counter's internal enable flop low after disable.
  - `cnt_of` lets the counter's self-clearing overflow flop clear.

Overflow and interrupt:
- `of_pend[i]` sets on `cnt_of[i]`.
- A write to sel 3 clears bits where wdata = 1 (write-1-to-clear).
- If a set and a clear hit the same bit in the same cycle, set wins.
- `hpcp_of_irq = |(of_pend & irq_en)`, taken from registers.

CSR FSM with states IDLE, WRITE, READ, RESP:
- IDLE: if req is high, latch wr/sel/idx/wdata. Go to WRITE if wr, else READ.
- WRITE: perform the update, then go to RESP.
  - sel 0: pulse `ctrl_cnt_wen[idx]` with `ctrl_hpcp_wdata = wdata`.
  - sel 1: `evt_sel[idx] <= wdata[EVT_W-1:0]`.
  - sel 2: `ctrl` takes the defined bits.
  - sel 3: W1C on `of_pend`.
- READ: register the read mux into `rdata_q`, then go to RESP.
  - sel 0: `cnt_value[idx]`.
  - sel 1: `evt_sel[idx]`, zero-extended.
  - sel 2: `ctrl`.
  - sel 3: `of_pend`.
- RESP: pulse ack and drive `rdata_q` on rdata (reads only), then go to IDLE.
- An index `>= CNT_NUM` (sel 0/1): writes are dropped, reads return 0, ack is still given.
- `ctrl_cnt_wen` is a one-hot pulse, asserted only in WRITE. `ctrl_hpcp_wdata` is 0 outside WRITE.

## Timing
- Write: req sampled at edge T. `ctrl_cnt_wen` is high in cycle T+1; the counter holds the new value from edge T+2. Ack in cycle T+2.
- Read: ack plus data in cycle T+2. `cnt_value` is sampled in cycle T+1.
- Requester drops req in the cycle after ack. A request present in IDLE is accepted with no bubble beyond RESP→IDLE.
- Event path: `evt_vld` at cycle E → `ctrl_cnt_adder` at E+1 → the counter registers it at the E+2 edge → increment at the E+3 edge.
- Counter write and increment in the same cycle: the counter's own write priority applies; the controller adds nothing.
- Changes to inhibit and `evt_sel` take effect on `ctrl_cnt_en` the cycle after the write edge.
- Reset mid-access: FSM to IDLE, no ack; all registers are cleared.

## Configuration
- `AQ_HPCP_OF_FREEZE_EN` defined:
  - `freeze = |of_pend`, so all counters stop while any overflow is pending.
  - Counting resumes the cycle after the last pending bit is cleared.
  - Counter writes still work while frozen.
- Not defined: `freeze` is tied to 0 and counters keep running past overflow.

## Structure
- Package `aq_hpcp_pkg`:
  - FSM state encodings.
  - `hpcp_csr_sel` encodings (CNT, EVT, CTRL, OFST).
  - Control-register bit offsets (inhibit at 0, irq_en at 32).
- Sub-module `aq_hpcp_evt_sel`, one per counter:
  - Holds the `evt_sel` register, event mux, enable logic, `en_d` and clock-enable generation.
  - The top holds the FSM, `ctrl`, `of_pend` and the read mux.

## Test plan
- Write sel 0 idx 2 with 0x0000_0000_DEAD_BEEF → `ctrl_cnt_wen` = 0x04 for exactly one cycle with that data; ack 2 cycles after req. A following read of idx 2 returns the counter value.
- `evt_sel[0]` = 3, `evt_vld[3]` high for 5 cycles → `ctrl_cnt_adder[0]` high for 5 cycles, delayed 1. Setting inhibit bit 0 drops `ctrl_cnt_en[0]`, and `ctrl_cnt_clk_en[0]` stays high exactly 1 more cycle.
- irq_en[1] = 1, `cnt_of[1]` pulse → `hpcp_of_irq` high the next cycle. A sel 3 write of 0x2 clears it; with the write coincident with a new `cnt_of[1]`, the bit stays set.
- Read sel 1 idx 31 with `CNT_NUM` = 8 → ack with rdata 0. A write to idx 31 changes no state.
- With `AQ_HPCP_OF_FREEZE_EN`: `cnt_of[4]` → all `ctrl_cnt_en` low while `of_pend` != 0, and restored after the W1C.
- `cpurst_b` low during READ → no ack; all outputs 0 and `of_pend`/`ctrl`/`evt_sel` = 0 after release.
